// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-addressed memory (async read, sync write)
// between a read-only instruction-fetch port and a load/store data port.
// Each port has a two-state IDLE/RESP sequencer and one registered response.
// The data port has priority unless the fetch port has been starved for
// MAX_WAIT consecutive cycles.
module mem_arbiter #(
  parameter int MEM_BYTES = 2048,
  parameter int MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic [63:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [63:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [1:0]  d_req_size,
  input  logic [63:0] d_req_wdata,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [63:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic [63:0] mem_addr,
  output logic [2:0]  mem_widthsel,
  output logic [63:0] mem_writedata,
  output logic        mem_we,
  input  logic [63:0] mem_readdata
);

  // Starvation counter is at least 3 bits and wide enough to hold MAX_WAIT.
  localparam int SW = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;
  localparam logic [64:0]   MEM_LIMIT = 65'(MEM_BYTES);
  localparam logic [SW-1:0] WAIT_LIM  = SW'(MAX_WAIT);
  localparam logic [SW-1:0] STARVE_MAX = {SW{1'b1}};

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  // Byte lanes kept for a load of the given size.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Memory width-select encoding for a transfer size.
  function automatic logic [2:0] size_widthsel(input logic [1:0] size);
    case (size)
      2'd0:    size_widthsel = 3'b000;
      2'd1:    size_widthsel = 3'b001;
      2'd2:    size_widthsel = 3'b011;
      default: size_widthsel = 3'b111;
    endcase
  endfunction

  // Out-of-range (65-bit, no wrap) or misaligned access.
  function automatic logic access_fault(input logic [63:0] addr, input logic [1:0] size);
    logic [64:0] nbytes;
    logic [64:0] end_addr;
    nbytes   = 65'd1 << size;
    end_addr = {1'b0, addr} + nbytes;
    access_fault = (end_addr > MEM_LIMIT) || ((addr & (nbytes[63:0] - 64'd1)) != 64'd0);
  endfunction

  state_t        if_state, if_next;
  state_t        d_state, d_next;
  logic [SW-1:0] starve;
  logic          if_consume, d_consume;
  logic          if_elig, d_elig;
  logic          if_grant, d_grant;
  logic          if_fault, d_fault;

  assign if_consume = (if_state == RESP) && if_rsp_ready;
  assign d_consume  = (d_state == RESP) && d_rsp_ready;
  assign if_elig    = !reset && if_req_valid && ((if_state == IDLE) || if_consume);
  assign d_elig     = !reset && d_req_valid && ((d_state == IDLE) || d_consume);
  assign if_grant   = if_elig && (!d_elig || (starve >= WAIT_LIM));
  assign d_grant    = d_elig && !if_grant;
  assign if_req_ready = if_grant;
  assign d_req_ready  = d_grant;
  assign if_fault   = access_fault(if_req_addr, 2'd2);
  assign d_fault    = access_fault(d_req_addr, d_req_size);

  // Drive the memory pins from whichever port owns this cycle.
  always_comb begin
    mem_addr      = 64'd0;
    mem_widthsel  = 3'b000;
    mem_writedata = 64'd0;
    mem_we        = 1'b0;
    if (d_grant) begin
      mem_addr      = d_fault ? 64'd0 : d_req_addr;
      mem_widthsel  = size_widthsel(d_req_size);
      mem_writedata = d_req_wdata;
      mem_we        = d_req_we && !d_fault && !reset;
    end else if (if_grant) begin
      mem_addr      = if_fault ? 64'd0 : if_req_addr;
      mem_widthsel  = 3'b011;
    end else begin
      mem_addr      = 64'd0;
    end
  end

  // Sequencer state registers for both ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_state <= IDLE;
      d_state  <= IDLE;
    end else begin
      if_state <= if_next;
      d_state  <= d_next;
    end
  end

  // Next-state logic: accept moves to RESP, a consumed response returns to IDLE.
  always_comb begin
    if_next = if_state;
    d_next  = d_state;
    case (if_state)
      IDLE:    if_next = if_grant ? RESP : IDLE;
      RESP:    if_next = if_grant ? RESP : (if_consume ? IDLE : RESP);
      default: if_next = IDLE;
    endcase
    case (d_state)
      IDLE:    d_next = d_grant ? RESP : IDLE;
      RESP:    d_next = d_grant ? RESP : (d_consume ? IDLE : RESP);
      default: d_next = IDLE;
    endcase
  end

  // Response-valid outputs decoded from the registered state.
  always_comb begin
    if_rsp_valid = (if_state == RESP);
    d_rsp_valid  = (d_state == RESP);
  end

  // Capture response payloads at the access edge; hold them otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rsp_data <= 64'd0;
      if_rsp_err  <= 1'b0;
      d_rsp_data  <= 64'd0;
      d_rsp_err   <= 1'b0;
    end else begin
      if (if_grant) begin
        if_rsp_data <= if_fault ? 64'd0 : (mem_readdata & size_mask(2'd2));
        if_rsp_err  <= if_fault;
      end else begin
        if_rsp_data <= if_rsp_data;
        if_rsp_err  <= if_rsp_err;
      end
      if (d_grant) begin
        d_rsp_data <= d_fault ? 64'd0 : (mem_readdata & size_mask(d_req_size));
        d_rsp_err  <= d_fault;
      end else begin
        d_rsp_data <= d_rsp_data;
        d_rsp_err  <= d_rsp_err;
      end
    end
  end

  // Saturating count of cycles an eligible fetch lost arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve <= '0;
    end else if (if_grant) begin
      starve <= '0;
    end else if (if_elig && (starve != STARVE_MAX)) begin
      starve <= starve + SW'(1);
    end else begin
      starve <= starve;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural byte memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
  logic [63:0] if_req_addr, if_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [1:0]  d_req_size;
  logic [63:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [63:0] mem_addr, mem_writedata, mem_readdata;
  logic [2:0]  mem_widthsel;
  logic        mem_we;

  logic [7:0]  mem [0:2047];
  int          errors = 0;
  int          checks = 0;

  mem_arbiter #(.MEM_BYTES(2048), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_size(d_req_size), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_widthsel(mem_widthsel), .mem_writedata(mem_writedata),
    .mem_we(mem_we), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Memory write port: commits on the clock edge.
  always @(posedge clk) begin
    int n;
    case (mem_widthsel)
      3'b000:  n = 1;
      3'b001:  n = 2;
      3'b011:  n = 4;
      default: n = 8;
    endcase
    if (mem_we) begin
      for (int i = 0; i < n; i++) begin
        if (mem_addr + 64'(i) < 64'd2048) mem[mem_addr[10:0] + 11'(i)] = mem_writedata[8*i +: 8];
      end
    end
  end

  // Asynchronous 8-byte little-endian read port.
  always_comb begin
    logic [63:0] a;
    a = 64'd0;
    mem_readdata = 64'd0;
    for (int i = 0; i < 8; i++) begin
      a = mem_addr + 64'(i);
      if (a < 64'd2048) mem_readdata[8*i +: 8] = mem[a[10:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[16'h10 + i] = 8'h88 - 8'(i * 8'h11);
    for (int i = 0; i < 8; i++) mem[16'h20 + i] = 8'hA0 + 8'(i);
    mem[11'h100] = 8'h78; mem[11'h101] = 8'h56; mem[11'h102] = 8'h34; mem[11'h103] = 8'h12;
    mem[11'h104] = 8'hFF;
    for (int i = 0; i < 8; i++) mem[11'h7F8 + 11'(i)] = 8'(i + 1);
    mem[3] = 8'h5A; mem[4] = 8'h6B;
    mem[11'h40] = 8'h33;

    // Reset with requests pending: no ready, no response.
    reset = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 64'h100; if_rsp_ready = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 64'h10; d_req_we = 1'b0; d_req_size = 2'd3;
    d_req_wdata = 64'd0; d_rsp_ready = 1'b0;
    step(); step();
    chk("rst_if_ready", {63'd0, if_req_ready}, 64'd0);
    chk("rst_d_ready", {63'd0, d_req_ready}, 64'd0);
    chk("rst_if_rsp_valid", {63'd0, if_rsp_valid}, 64'd0);
    chk("rst_d_rsp_valid", {63'd0, d_rsp_valid}, 64'd0);
    chk("rst_d_rsp_data", d_rsp_data, 64'd0);
    chk("rst_d_rsp_err", {63'd0, d_rsp_err}, 64'd0);
    chk("rst_if_rsp_data", if_rsp_data, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_widthsel", {61'd0, mem_widthsel}, 64'd0);
    reset = 1'b0; if_req_valid = 1'b0; d_req_valid = 1'b0;
    if_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
    step();

    // 8-byte load at 0x10.
    d_req_valid = 1'b1; d_req_addr = 64'h10; d_req_size = 2'd3; d_req_we = 1'b0;
    #1;
    chk("ld_ready", {63'd0, d_req_ready}, 64'd1);
    chk("ld_mem_addr", mem_addr, 64'h10);
    chk("ld_widthsel", {61'd0, mem_widthsel}, 64'd7);
    chk("ld_rsp_valid_early", {63'd0, d_rsp_valid}, 64'd0);
    step(); d_req_valid = 1'b0;
    chk("ld_rsp_valid", {63'd0, d_rsp_valid}, 64'd1);
    chk("ld_rsp_data", d_rsp_data, 64'h1122334455667788);
    chk("ld_rsp_err", {63'd0, d_rsp_err}, 64'd0);
    step();
    chk("ld_rsp_drop", {63'd0, d_rsp_valid}, 64'd0);

    // 16-bit store then back-to-back 8-byte load.
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_size = 2'd1; d_req_addr = 64'h20;
    d_req_wdata = 64'hBEEF;
    #1;
    chk("st_mem_we", {63'd0, mem_we}, 64'd1);
    chk("st_widthsel", {61'd0, mem_widthsel}, 64'd1);
    chk("st_wdata", mem_writedata, 64'hBEEF);
    step();
    chk("st_rsp_valid", {63'd0, d_rsp_valid}, 64'd1);
    chk("st_rsp_err", {63'd0, d_rsp_err}, 64'd0);
    d_req_we = 1'b0; d_req_size = 2'd3;
    #1;
    chk("b2b_ready", {63'd0, d_req_ready}, 64'd1);
    step(); d_req_valid = 1'b0;
    chk("st_ld_data", d_rsp_data, 64'hA7A6A5A4A3A2BEEF);
    step();

    // Starvation: fetch wins on cycle 5, data takes the other 10 cycles.
    d_req_valid = 1'b1; d_req_addr = 64'h10; d_req_size = 2'd2; d_req_we = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 64'h100;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      #1;
      chk($sformatf("arb_if_ready_c%0d", cyc), {63'd0, if_req_ready}, (cyc == 5) ? 64'd1 : 64'd0);
      chk($sformatf("arb_d_ready_c%0d", cyc), {63'd0, d_req_ready}, (cyc == 5) ? 64'd0 : 64'd1);
      if (cyc == 5) begin
        chk("arb_if_addr", mem_addr, 64'h100);
        chk("arb_if_widthsel", {61'd0, mem_widthsel}, 64'd3);
      end
      step();
      if (cyc == 5) begin
        if_req_valid = 1'b0;
        chk("arb_if_rsp_valid", {63'd0, if_rsp_valid}, 64'd1);
        chk("arb_if_rsp_data", if_rsp_data, 64'h12345678);
        chk("arb_if_rsp_err", {63'd0, if_rsp_err}, 64'd0);
      end else begin
        chk($sformatf("arb_d_data_c%0d", cyc), d_rsp_data, 64'h55667788);
      end
    end
    d_req_valid = 1'b0;
    step();

    // Faults and range boundary.
    d_req_valid = 1'b1; d_req_addr = 64'h7FE; d_req_size = 2'd2;
    #1;
    chk("flt_mem_addr", mem_addr, 64'd0);
    step();
    chk("flt_err", {63'd0, d_rsp_err}, 64'd1);
    chk("flt_data", d_rsp_data, 64'd0);
    d_req_addr = 64'h7F8; d_req_size = 2'd3;
    #1;
    chk("edge_mem_addr", mem_addr, 64'h7F8);
    step();
    chk("edge_err", {63'd0, d_rsp_err}, 64'd0);
    chk("edge_data", d_rsp_data, 64'h0807060504030201);
    d_req_addr = 64'hFFFF_FFFF_FFFF_FFFC; d_req_size = 2'd2;
    step();
    chk("wrap_err", {63'd0, d_rsp_err}, 64'd1);
    d_req_we = 1'b1; d_req_size = 2'd1; d_req_addr = 64'h3; d_req_wdata = 64'hFFFF;
    #1;
    chk("flt_st_we", {63'd0, mem_we}, 64'd0);
    step();
    d_req_valid = 1'b0; d_req_we = 1'b0;
    chk("flt_st_err", {63'd0, d_rsp_err}, 64'd1);
    chk("flt_st_byte3", {56'd0, mem[3]}, 64'h5A);
    chk("flt_st_byte4", {56'd0, mem[4]}, 64'h6B);
    step();

    // Data response held while fetch keeps flowing.
    d_req_valid = 1'b1; d_req_addr = 64'h10; d_req_size = 2'd3;
    step();
    d_rsp_ready = 1'b0; d_req_addr = 64'h20;
    if_req_valid = 1'b1; if_req_addr = 64'h100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold_d_ready_%0d", k), {63'd0, d_req_ready}, 64'd0);
      chk($sformatf("hold_if_ready_%0d", k), {63'd0, if_req_ready}, 64'd1);
      chk($sformatf("hold_d_valid_%0d", k), {63'd0, d_rsp_valid}, 64'd1);
      chk($sformatf("hold_d_data_%0d", k), d_rsp_data, 64'h1122334455667788);
      step();
      chk($sformatf("hold_if_rsp_%0d", k), if_rsp_data, 64'h12345678);
    end
    if_req_valid = 1'b0; d_rsp_ready = 1'b1;
    #1;
    chk("hold_release_ready", {63'd0, d_req_ready}, 64'd1);
    step(); d_req_valid = 1'b0;
    chk("hold_next_data", d_rsp_data, 64'hA7A6A5A4A3A2BEEF);
    step();

    // Reset on the same edge as a store; pending responses dropped.
    if_rsp_ready = 1'b0; d_rsp_ready = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 64'h100;
    d_req_valid = 1'b1; d_req_addr = 64'h10; d_req_size = 2'd3;
    step(); step();
    chk("pre_rst_d_valid", {63'd0, d_rsp_valid}, 64'd1);
    chk("pre_rst_if_valid", {63'd0, if_rsp_valid}, 64'd1);
    if_req_valid = 1'b0; d_rsp_ready = 1'b1;
    d_req_we = 1'b1; d_req_size = 2'd0; d_req_addr = 64'h40; d_req_wdata = 64'h99;
    reset = 1'b1;
    #1;
    chk("rst_st_we", {63'd0, mem_we}, 64'd0);
    step();
    reset = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
    chk("rst_st_byte", {56'd0, mem[11'h40]}, 64'h33);
    chk("rst_st_d_valid", {63'd0, d_rsp_valid}, 64'd0);
    chk("rst_st_if_valid", {63'd0, if_rsp_valid}, 64'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-ported byte-addressed main memory (async read, sync write). It shares the memory between the instruction-fetch port (read-only) and the data port (load/store) and drives the memory's addr/widthsel/writedata/WE pins. It range- and alignment-checks every access and returns one registered response per accepted request. Only one access is outstanding per requester.

## Interface
- MEM_BYTES, 2048: memory size in bytes; legal byte addresses are 0 .. MEM_BYTES-1.
- MAX_WAIT, 4: number of consecutive cycles a stalled fetch request waits before it preempts data priority.
- clk  in  1  clock; the single clock domain.
- reset  in  1  synchronous, active-high reset.
- if_req_valid / if_req_ready  in / out  1 / 1  fetch request handshake.
- if_req_addr  in  64  fetch byte address; fetch size is always 32-bit.
- if_rsp_valid / if_rsp_ready  out / in  1 / 1  fetch response handshake.
- if_rsp_data  out  64  fetch data, zero-extended from 32 bits.
- if_rsp_err  out  1  access fault on fetch.
- d_req_valid / d_req_ready  in / out  1 / 1  data request handshake.
- d_req_addr  in  64  data byte address.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_size  in  2  transfer size: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = 64-bit.
- d_req_wdata  in  64  store data, little-endian, LSB-aligned.
- d_rsp_valid / d_rsp_ready  out / in  1 / 1  data response handshake.
- d_rsp_data / d_rsp_err  out  64 / 1  load data (zero-extended) and access-fault flag.
- mem_addr  out  64  memory byte address.
- mem_widthsel  out  3  memory width select: 000 = 8-bit, 001 = 16-bit, 011 = 32-bit, 111 = 64-bit.
- mem_writedata  out  64  memory write data.
- mem_we  out  1  memory write enable.
- mem_readdata  in  64  memory read data (async).

## Operation
- A request is accepted when valid && ready are both high at a clock edge. That edge is the access cycle.
- Combinationally during that cycle, the block:
  - drives mem_addr, mem_widthsel and mem_writedata from the winning requester;
  - asserts mem_we only for a legal store;
  - samples mem_readdata into that requester's response register at the edge.
- Per requester, a 2-state FSM: IDLE, then RESP.
  - IDLE -> RESP when a request is accepted.
  - RESP -> IDLE when rsp_valid && rsp_ready is high at the edge.
  - RESP -> RESP (back-to-back) when the response is consumed and a new request is accepted in the same cycle.
- req_ready for a requester = (its FSM is IDLE, or its response is being consumed this cycle) && it wins arbitration.
- Arbitration applies only when both requesters are eligible:
  - the data port wins by default;
  - the fetch port wins if its starvation counter is at or above MAX_WAIT.
- Starvation counter:
  - it is 3+ bits wide and saturates;
  - it increments each cycle that an eligible fetch request loses arbitration;
  - it clears when a fetch request is accepted.
- Fault checks:
  - nbytes = 1 << size;
  - err = (addr + nbytes > MEM_BYTES), computed in 65-bit arithmetic so there is no wrap, OR (addr mod nbytes != 0).
- On a faulting access:
  - mem_we stays low;
  - mem_addr is driven to 0;
  - rsp_err = 1;
  - rsp_data = 0.
- Load data is mem_readdata masked to nbytes. Store data is sent to memory unmasked, with widthsel limiting the bytes written.
- When there is no grant: mem_we = 0, mem_addr = 0, mem_widthsel = 000.
- Response outputs hold stable while rsp_valid is high and rsp_ready is low.

## Timing
- Reset values:
  - if_req_ready = d_req_ready = 0 during reset;
  - both rsp_valid = 0, rsp_data = 0, rsp_err = 0;
  - FSMs = IDLE;
  - starvation counter = 0;
  - mem_we = 0.
- Latency: rsp_valid rises on the cycle after acceptance, with 1-cycle access latency.
- A store commits to memory at the acceptance edge. A load issued the next cycle to the same address returns the new data.
- Throughput: one access per cycle in total across both ports when rsp_ready is held high.
- Reset asserted mid-transaction:
  - any pending response is dropped;
  - a store accepted in the same edge as reset is suppressed, because mem_we is gated by !reset.
- The ready signals depend combinationally on rsp_ready and valid only. No path runs from mem_readdata to any ready signal.

## Test plan
- Reset, then data load of 8 bytes at 0x10 after the bench preloads 0x1122334455667788: d_rsp_valid rises 1 cycle after acceptance, d_rsp_data = 0x1122334455667788, err = 0.
- Store size 1 of 0xBEEF to 0x20, then load size 3 from 0x20: byte 0x20 = 0xEF, byte 0x21 = 0xBE, other bytes unchanged.
- Fetch and data both valid continuously, with data issuing 10 back-to-back loads: the fetch is granted on cycle MAX_WAIT+1 (cycle 5), then data resumes.
- Load size 2 at 0x7FE with MEM_BYTES = 2048: err = 1, data = 0. Store size 1 at 0x3: err = 1 and memory is unchanged.
- Hold d_rsp_ready low for 3 cycles after a load: d_req_ready stays low, d_rsp_data stays stable, and fetch traffic proceeds unaffected.
- Assert reset on the same edge as a store to 0x40: mem_we = 0, byte 0x40 keeps its old value, and all rsp_valid = 0 the next cycle.
